// File: rtl/dram_responder_pkg.sv
// Shared encodings for the DRAM responder: access sizes, ctrl bit, FSM states.
// Lane helpers keep the byte-enable and extension rules in one place.
package dram_responder_pkg;

  localparam logic [1:0] DRAM_SZ_BYTE  = 2'd0;
  localparam logic [1:0] DRAM_SZ_HALF  = 2'd1;
  localparam logic [1:0] DRAM_SZ_WORD  = 2'd2;
  localparam int         DRAM_CTRL_UNS = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2
  } state_e;

  function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      DRAM_SZ_BYTE: misaligned = 1'b0;
      DRAM_SZ_HALF: misaligned = off[0];
      default:      misaligned = (off != 2'b00);
    endcase
  endfunction

  // Size 3 behaves as a word everywhere.
  function automatic logic [1:0] align_off(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      DRAM_SZ_BYTE: align_off = off;
      DRAM_SZ_HALF: align_off = {off[1], 1'b0};
      default:      align_off = 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      DRAM_SZ_BYTE: byte_en = 4'b0001 << off;
      DRAM_SZ_HALF: byte_en = off[1] ? 4'b1100 : 4'b0011;
      default:      byte_en = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [31:0] lane, input logic [1:0] sz,
                                           input logic uns);
    case (sz)
      DRAM_SZ_BYTE: load_ext = {{24{~uns & lane[7]}}, lane[7:0]};
      DRAM_SZ_HALF: load_ext = {{16{~uns & lane[15]}}, lane[15:0]};
      default:      load_ext = lane;
    endcase
  endfunction

endpackage

// File: rtl/dram_resp_mem.sv
// 2**ADDR_W x 32 RAM with per-byte write enables and a registered read port.
// Read-during-write to the same word returns the old contents.
module dram_resp_mem #(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [3:0]        we,
  input  logic [31:0]       wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata
);

  logic [31:0] mem_q [2**ADDR_W];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem_q[waddr][8*i +: 8] <= wdata[8*i +: 8];
    end
    rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dram_responder.sv
// Single-outstanding DRAM responder: busy for LAT cycles per access, RAM write/odata update on completion.
// Optional misalignment checking when DRAM_RESP_CHK_EN is defined (adds dram_err).
module dram_responder
  import dram_responder_pkg::*;
#(
  parameter int ADDR_W = 14,
  parameter int LAT    = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] dram_addr,
  input  logic [31:0] dram_wdata,
  input  logic        dram_le,
  input  logic        dram_we_t,
  input  logic [2:0]  dram_ctrl,
  output logic [31:0] dram_odata,
`ifdef DRAM_RESP_CHK_EN
  output logic        dram_err,
`endif
  output logic        dram_busy
);

  localparam logic [7:0] LAT_C = 8'(LAT);

  state_e            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] widx_q, widx_d;
  logic [1:0]        off_q, off_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [2:0]        ctrl_q, ctrl_d;
  logic [31:0]       odata_q, odata_d;
  logic              accept, complete, bad;
  logic [1:0]        eff_off;
  logic [3:0]        mem_we;
  logic [31:0]       mem_wdata, mem_rdata, lane;
  logic [ADDR_W-1:0] mem_raddr;
  logic              unused_addr_hi;
`ifdef DRAM_RESP_CHK_EN
  logic              err_q, err_d;
`endif

  assign unused_addr_hi = ^dram_addr[31:ADDR_W+2];

  always_ff @(posedge CLK) begin
    if (RST) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (dram_we_t)    state_d = ST_WR;
        else if (dram_le) state_d = ST_RD;
      end
      ST_RD, ST_WR: if (cnt_q == LAT_C) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    accept   = (state_q == ST_IDLE) && (dram_we_t || dram_le);
    complete = (state_q != ST_IDLE) && (cnt_q == LAT_C);
`ifdef DRAM_RESP_CHK_EN
    bad      = misaligned(ctrl_q[1:0], off_q);
`else
    bad      = 1'b0;
`endif
    eff_off  = align_off(ctrl_q[1:0], off_q);

    cnt_d = cnt_q;
    if (accept)                  cnt_d = 8'd1;
    else if (complete)           cnt_d = 8'd0;
    else if (state_q != ST_IDLE) cnt_d = cnt_q + 8'd1;

    widx_d  = widx_q;
    off_d   = off_q;
    wdata_d = wdata_q;
    ctrl_d  = ctrl_q;
    if (accept) begin
      widx_d  = dram_addr[ADDR_W+1:2];
      off_d   = dram_addr[1:0];
      wdata_d = dram_wdata;
      ctrl_d  = dram_ctrl;
    end

    // In IDLE the RAM already looks at the incoming address so LAT=1 loads have data in time.
    mem_raddr = (state_q == ST_IDLE) ? dram_addr[ADDR_W+1:2] : widx_q;

    mem_we = 4'b0000;
    if (state_q == ST_WR && complete && !bad && !RST) mem_we = byte_en(ctrl_q[1:0], eff_off);

    case (ctrl_q[1:0])
      DRAM_SZ_BYTE: mem_wdata = {4{wdata_q[7:0]}};
      DRAM_SZ_HALF: mem_wdata = {2{wdata_q[15:0]}};
      default:      mem_wdata = wdata_q;
    endcase

    lane    = mem_rdata >> {eff_off, 3'b000};
    odata_d = odata_q;
    if (state_q == ST_RD && complete && !bad)
      odata_d = load_ext(lane, ctrl_q[1:0], ctrl_q[DRAM_CTRL_UNS]);
`ifdef DRAM_RESP_CHK_EN
    err_d = complete && bad;
`endif
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q   <= 8'd0;
      odata_q <= 32'd0;
      widx_q  <= '0;
      off_q   <= 2'd0;
      wdata_q <= 32'd0;
      ctrl_q  <= 3'd0;
`ifdef DRAM_RESP_CHK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      cnt_q   <= cnt_d;
      odata_q <= odata_d;
      widx_q  <= widx_d;
      off_q   <= off_d;
      wdata_q <= wdata_d;
      ctrl_q  <= ctrl_d;
`ifdef DRAM_RESP_CHK_EN
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    dram_busy  = (state_q != ST_IDLE);
    dram_odata = odata_q;
`ifdef DRAM_RESP_CHK_EN
    dram_err   = err_q;
`endif
  end

  dram_resp_mem #(.ADDR_W(ADDR_W)) u_mem (
    .clk   (CLK),
    .waddr (widx_q),
    .we    (mem_we),
    .wdata (mem_wdata),
    .raddr (mem_raddr),
    .rdata (mem_rdata)
  );

endmodule
